cp0_exc: RTL

CP0_EXC -- requirements
Module: cp0_exc

---
 rtl/cp0_exc.sv | 110 +++++++++++
 1 files changed

// File: rtl/cp0_exc.sv
// cp0_exc: MIPS-style CP0 subset with Count/Compare timer, interrupt gating,
// exception/ERET state capture and MTC0/MFC0 register access.
module cp0_exc #(
    parameter int          NUM_HW_INT = 6,
    parameter int          TIMER_IRQ  = 5,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           rdata_o,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badva_i,
    input  logic                  eret_i,
    output logic                  int_req_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic                  timer_int_o
);
    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;
    localparam logic [31:0] CU0         = 32'h1000_0000;

    logic [3:0]  div;
    logic [31:0] count, compare, status, epc, badva, cause, status_w, cause_fwd;
    logic        cause_bd, cause_iv, cause_wp, timer_int;
    logic [1:0]  ip_sw;
    logic [5:0]  ip_hw, hw;
    logic [4:0]  exc_code;
    logic        tick, first, wr_count, wr_compare, wr_status, wr_cause, wr_epc, fwd;

    assign tick       = div == 4'(COUNT_DIV - 1);
    assign first      = exc_valid_i && !status[1];
    assign wr_count   = we_i && waddr_i == 5'd9;
    assign wr_compare = we_i && waddr_i == 5'd11;
    assign wr_status  = we_i && waddr_i == 5'd12;
    assign wr_cause   = we_i && waddr_i == 5'd13;
    assign wr_epc     = we_i && waddr_i == 5'd14;
    assign fwd        = we_i && waddr_i == raddr_i;
    assign status_w   = wr_status ? (wdata_i | CU0) : status;
    assign cause      = {cause_bd, 7'b0, cause_iv, cause_wp, 6'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
    assign cause_fwd  = (cause & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);

    always_comb begin
        hw = 6'(int_i);
        hw[TIMER_IRQ] = hw[TIMER_IRQ] | timer_int;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div       <= '0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
            status    <= CU0;
            epc       <= '0;
            badva     <= '0;
            cause_bd  <= 1'b0;
            cause_iv  <= 1'b0;
            cause_wp  <= 1'b0;
            ip_sw     <= '0;
            ip_hw     <= '0;
            exc_code  <= '0;
        end else begin
            div       <= (tick || wr_count) ? '0 : div + 4'd1;
            count     <= wr_count ? wdata_i : tick ? count + 32'd1 : count;
            compare   <= wr_compare ? wdata_i : compare;
            // Compare write acknowledges the timer and beats a same-cycle match
            timer_int <= wr_compare ? 1'b0 : timer_int | (count == compare && compare != '0);
            status    <= exc_valid_i ? (status_w | 32'h2) : eret_i ? (status_w & ~32'h2) : status_w;
            epc       <= first ? (exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i) : wr_epc ? wdata_i : epc;
            badva     <= (exc_valid_i && (exc_code_i == 5'd4 || exc_code_i == 5'd5)) ? exc_badva_i : badva;
            cause_bd  <= first ? exc_bd_i : cause_bd;
            exc_code  <= exc_valid_i ? exc_code_i : exc_code;
            cause_iv  <= wr_cause ? wdata_i[23] : cause_iv;
            cause_wp  <= wr_cause ? wdata_i[22] : cause_wp;
            ip_sw     <= wr_cause ? wdata_i[9:8] : ip_sw;
            ip_hw     <= hw;
        end
    end

    always_comb begin
        case (raddr_i)
            5'd8:    rdata_o = badva;
            5'd9:    rdata_o = fwd ? wdata_i : count;
            5'd11:   rdata_o = fwd ? wdata_i : compare;
            5'd12:   rdata_o = fwd ? (wdata_i | CU0) : status;
            5'd13:   rdata_o = fwd ? cause_fwd : cause;
            5'd14:   rdata_o = fwd ? wdata_i : epc;
            5'd15:   rdata_o = PRID_VAL;
            5'd16:   rdata_o = CONFIG_VAL;
            default: rdata_o = '0;
        endcase
    end

    assign int_req_o   = |(cause[15:8] & status[15:8]) & status[0] & ~status[1];
    assign epc_o       = epc;
    assign status_o    = status;
    assign cause_o     = cause;
    assign timer_int_o = timer_int;
endmodule
